pixel_row_adc_readout: RTL

Parametrised successor to the pixel row. It holds per-column single-slope ADC capture for one row of the pixel array, driven by its own ramp-code counter. It then streams the captured values out on a valid/ready bus, CHANNELS columns per beat. It sits between the analog pixel comparators of one row and the frame readout/interface logic, and replaces the externally driven COUNTER/READ scheme with a self-sequenced conversion and readout.

---
 rtl/pixel_row_adc_readout_pkg.sv | 16 +
 rtl/pixel_row_adc_readout_column.sv | 40 ++++
 rtl/pixel_row_adc_readout.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pixel_row_adc_readout_pkg.sv
// Shared types and helpers for the pixel row single-slope ADC readout.
package PixelSensorConfig;

   // Row sequencer states: idle, ramp conversion, beat streaming.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      READOUT = 2'd2
   } row_adc_state_t;

   // $clog2 that never returns less than one bit, for counters and indices.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pixel_row_adc_readout_column.sv
// One column of the row: captures the ramp code at the first comparator trip
// of a conversion, or the full-scale code when the pixel never trips.
module pixel_column_latch
   import PixelSensorConfig::*;
#(
   parameter int PIXEL_BITS = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  CLEAR,
   input  logic                  ENABLE,
   input  logic                  SATURATE,
   input  logic                  CMP,
   input  logic [PIXEL_BITS-1:0] CODE,
   output logic [PIXEL_BITS-1:0] VALUE,
   output logic                  TRIPPED
);

   typedef logic [PIXEL_BITS-1:0] pixel_code_t;
   localparam pixel_code_t PIXEL_CODE_MAX = '1;

   // First trip wins; later comparator activity is ignored until CLEAR.
   // A trip in the final ramp cycle outranks saturation (both give the same
   // code, but TRIPPED must reflect the real crossing).
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         VALUE   <= '0;
         TRIPPED <= 1'b0;
      end else if (CLEAR) begin
         VALUE   <= '0;
         TRIPPED <= 1'b0;
      end else if (ENABLE && CMP && !TRIPPED) begin
         VALUE   <= CODE;
         TRIPPED <= 1'b1;
      end else if (SATURATE && !TRIPPED) begin
         VALUE   <= PIXEL_CODE_MAX;
      end
   end

endmodule

// File: rtl/pixel_row_adc_readout.sv
// Row ADC: self-sequenced single-slope conversion of WIDTH columns followed
// by a CHANNELS-wide valid/ready stream of the captured codes.
//
// Output handshake: OUT_VALID is high exactly while in READOUT. A beat
// transfers on a rising edge where OUT_VALID and OUT_READY are both high;
// while OUT_VALID is high and OUT_READY low, OUT_DATA/OUT_COL/OUT_LAST are
// held. The next beat follows the transfer with no idle cycle in between.
module pixel_row_adc_readout
   import PixelSensorConfig::*;
#(
   parameter int WIDTH      = 8,
   parameter int PIXEL_BITS = 8,
   parameter int CHANNELS   = 2,
   parameter int ROW_INDEX  = 0
) (
   input  logic                                    CLK,
   input  logic                                    RESET,
   input  logic                                    START,
   input  logic                                    ABORT,
   input  logic [WIDTH-1:0]                        CMP,
   output logic [PIXEL_BITS-1:0]                   RAMP_CODE,
   output logic                                    BUSY,
   output logic                                    DONE,
   output logic [CHANNELS*PIXEL_BITS-1:0]          OUT_DATA,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] OUT_COL,
   output logic [15:0]                             OUT_ROW,
   output logic                                    OUT_LAST,
   output logic                                    OUT_VALID,
   input  logic                                    OUT_READY,
   output row_adc_state_t                          DBG_STATE,
   output logic [WIDTH-1:0]                        DBG_TRIPPED
);

   typedef logic [PIXEL_BITS-1:0] pixel_code_t;
   localparam pixel_code_t PIXEL_CODE_MAX = '1;

   localparam int BEATS  = WIDTH / CHANNELS;
   localparam int BEAT_W = clog2_min1(BEATS);
   localparam int COL_W  = clog2_min1(WIDTH);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

   generate
      if (WIDTH < 1 || CHANNELS < 1 || (WIDTH % CHANNELS) != 0) begin : g_bad_cfg
         $error("pixel_row_adc_readout: WIDTH must be a positive multiple of CHANNELS");
      end
   endgenerate

   row_adc_state_t    state;
   pixel_code_t       ramp;
   logic [BEAT_W-1:0] beat;
   logic              done_q;

   pixel_code_t       col_value [WIDTH];
   logic [WIDTH-1:0]  col_tripped;
   logic              col_clear;
   logic              col_enable;
   logic              col_saturate;
   logic [CHANNELS*PIXEL_BITS-1:0] beat_data;
   int                beat_base;

   // ABORT outranks START everywhere, including the IDLE start condition.
   assign col_clear    = (state == IDLE) && START && !ABORT;
   assign col_enable   = (state == CONVERT) && !ABORT;
   assign col_saturate = col_enable && (ramp == PIXEL_CODE_MAX);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
         pixel_column_latch #(
            .PIXEL_BITS(PIXEL_BITS)
         ) u_latch (
            .CLK      (CLK),
            .RESET    (RESET),
            .CLEAR    (col_clear),
            .ENABLE   (col_enable),
            .SATURATE (col_saturate),
            .CMP      (CMP[i]),
            .CODE     (ramp),
            .VALUE    (col_value[i]),
            .TRIPPED  (col_tripped[i])
         );
      end
   endgenerate

   // Sequencer: ramp counter during CONVERT, beat counter during READOUT.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         ramp   <= '0;
         beat   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (START && !ABORT) begin
                  state <= CONVERT;
                  ramp  <= '0;
                  beat  <= '0;
               end
            end
            CONVERT: begin
               if (ABORT) begin
                  state <= IDLE;
                  ramp  <= '0;
               end else if (ramp == PIXEL_CODE_MAX) begin
                  state <= READOUT;
                  ramp  <= '0;
                  beat  <= '0;
               end else begin
                  ramp <= ramp + PIXEL_BITS'(1);
               end
            end
            READOUT: begin
               if (ABORT) begin
                  state <= IDLE;
                  beat  <= '0;
               end else if (OUT_READY) begin
                  if (beat == BEAT_LAST) begin
                     state  <= IDLE;
                     beat   <= '0;
                     done_q <= 1'b1;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               ramp  <= '0;
               beat  <= '0;
            end
         endcase
      end
   end

   // Beat mux: lane j carries column beat*CHANNELS + j.
   always_comb begin
      beat_data = '0;
      beat_base = int'(beat) * CHANNELS;
      for (int j = 0; j < CHANNELS; j++) begin
         beat_data[j*PIXEL_BITS +: PIXEL_BITS] = col_value[beat_base + j];
      end
   end

   assign RAMP_CODE   = ramp;
   assign BUSY        = (state != IDLE);
   assign DONE        = done_q;
   assign OUT_VALID   = (state == READOUT);
   assign OUT_LAST    = (state == READOUT) && (beat == BEAT_LAST);
   assign OUT_DATA    = beat_data;
   assign OUT_COL     = COL_W'(int'(beat) * CHANNELS);
   assign OUT_ROW     = 16'(ROW_INDEX);
   assign DBG_STATE   = state;
   assign DBG_TRIPPED = col_tripped;

endmodule
